// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GEMM tile scheduler.
package gemm_pkg;

  localparam int GemmSizeW = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    ADVANCE,
    FINISH
  } sched_state_e;

  // One guard bit above the size width keeps X + lanes-1 from wrapping.
  function automatic logic [GemmSizeW:0] ceil_div_pow2(input logic [GemmSizeW:0] x,
                                                       input int unsigned lg2);
    logic [GemmSizeW:0] bias;
    bias = ((GemmSizeW+1)'(1) << lg2) - (GemmSizeW+1)'(1);
    return (x + bias) >> lg2;
  endfunction

endpackage

// File: rtl/gemm_tile_scheduler_if.sv
// Scheduler-to-core tile handshake: start pulse plus tile coordinates, done pulse back.
interface gemm_tile_scheduler_if #(
  parameter int SizeAddrWidth = 8
);
  logic                     start;
  logic [SizeAddrWidth-1:0] k_size;
  logic [SizeAddrWidth-1:0] n_size;
  logic [SizeAddrWidth-1:0] m_count;
  logic [SizeAddrWidth-1:0] n_count;
  logic                     done;

  modport master (output start, k_size, n_size, m_count, n_count, input done);
  modport slave  (input start, k_size, n_size, m_count, n_count, output done);
endinterface

// File: rtl/gemm_tile_scheduler.sv
// Walks an M x N GEMM job tile by tile (N inner, M outer), one core start per tile.
//
// state   | meaning
// IDLE    | ready for a job request
// LAUNCH  | one-cycle start pulse to the core
// WAIT    | core working on current tile
// ADVANCE | step tile counters or decide job is complete
// FINISH  | one-cycle job-done pulse
module gemm_tile_scheduler
  import gemm_pkg::*;
#(
  parameter int SizeAddrWidth    = GemmSizeW,
  parameter int NumParallelLanes = 4,
  parameter int TileCntWidth     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic                     abort_i,
  gemm_tile_scheduler_if.master    core,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     aborted_o,
  output logic                     err_o,
  output logic [TileCntWidth-1:0]  tiles_done_o
);

  localparam int unsigned LaneLog2 = $clog2(NumParallelLanes);

  sched_state_e             state_q, state_d;
  logic [SizeAddrWidth-1:0] k_q, k_d, n_q, n_d;
  logic [SizeAddrWidth:0]   mt_q, mt_d, nt_q, nt_d;
  logic [SizeAddrWidth-1:0] m_cnt_q, m_cnt_d, n_cnt_q, n_cnt_d;
  logic [TileCntWidth-1:0]  tiles_q, tiles_d;
  logic                     err_q, err_d, aborted_q, aborted_d;
  logic                     zero_req;

  assign zero_req = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    n_d       = n_q;
    mt_d      = mt_q;
    nt_d      = nt_q;
    m_cnt_d   = m_cnt_q;
    n_cnt_d   = n_cnt_q;
    tiles_d   = tiles_q;
    err_d     = 1'b0;
    aborted_d = 1'b0;

    if (abort_i && (state_q != IDLE)) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid_i) begin
            if (zero_req) begin
              err_d = 1'b1;
            end else begin
              k_d     = K_size_i;
              n_d     = N_size_i;
              mt_d    = ceil_div_pow2((GemmSizeW+1)'(M_size_i), LaneLog2);
              nt_d    = ceil_div_pow2((GemmSizeW+1)'(N_size_i), LaneLog2);
              m_cnt_d = SizeAddrWidth'(1);
              n_cnt_d = SizeAddrWidth'(1);
              tiles_d = '0;
              state_d = LAUNCH;
            end
          end
        end
        LAUNCH: state_d = WAIT;
        WAIT: begin
          if (core.done) begin
            if (tiles_q != '1) tiles_d = tiles_q + TileCntWidth'(1);
            state_d = ADVANCE;
          end
        end
        ADVANCE: begin
          if ({1'b0, n_cnt_q} < nt_q) begin
            n_cnt_d = n_cnt_q + SizeAddrWidth'(1);
            state_d = LAUNCH;
          end else if ({1'b0, m_cnt_q} < mt_q) begin
            n_cnt_d = SizeAddrWidth'(1);
            m_cnt_d = m_cnt_q + SizeAddrWidth'(1);
            state_d = LAUNCH;
          end else begin
            state_d = FINISH;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      k_q       <= '0;
      n_q       <= '0;
      mt_q      <= '0;
      nt_q      <= '0;
      m_cnt_q   <= SizeAddrWidth'(1);
      n_cnt_q   <= SizeAddrWidth'(1);
      tiles_q   <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      n_q       <= n_d;
      mt_q      <= mt_d;
      nt_q      <= nt_d;
      m_cnt_q   <= m_cnt_d;
      n_cnt_q   <= n_cnt_d;
      tiles_q   <= tiles_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  // An abort landing on LAUNCH/FINISH suppresses that cycle's pulse.
  assign core.start   = (state_q == LAUNCH) && !abort_i;
  assign done_o       = (state_q == FINISH) && !abort_i;
  assign core.k_size  = k_q;
  assign core.n_size  = n_q;
  assign core.m_count = m_cnt_q;
  assign core.n_count = n_cnt_q;
  assign busy_o       = (state_q != IDLE);
  assign cfg_ready_o  = (state_q == IDLE);
  assign aborted_o    = aborted_q;
  assign err_o        = err_q;
  assign tiles_done_o = tiles_q;

endmodule
